// File: rtl/lram_port_arbiter_pkg.sv
// Shared types and constants for the LUTRAM port arbiter.
//   state_t     : top-level mode, SERVE (arbitrate requesters) or INIT (clear RAM)
//   DEF_*       : default widths for a 4-requester, 64x8 configuration
//   LRAM_DEPTH  : depth of the default RAM
//   rr_index    : position of the k-th candidate in a wrap-around search
package lram_port_arbiter_pkg;

  typedef enum logic {
    SERVE = 1'b0,
    INIT  = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int LRAM_DEPTH     = 2 ** DEF_ADDR_WIDTH;

  // Requester index visited at step 'off' of a search that starts at 'base'.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/lram_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : index that has highest priority this cycle
//   enable    : 0 forces an all-zero grant
//   grant     : one-hot winner, or zero when nobody wins
//   grant_idx : binary index of the winner (0 when grant is zero)
module rr_arbiter
  import lram_port_arbiter_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic found;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req[rr_index(int'(ptr), k, N)]) begin
          found                        = 1'b1;
          grant[rr_index(int'(ptr), k, N)] = 1'b1;
          grant_idx                    = PW'(rr_index(int'(ptr), k, N));
        end
      end
    end
  end

endmodule

// File: rtl/lram_port_arbiter.sv
// Shares one single-write-port LUTRAM between NUM_REQ valid/ready requesters.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   init / busy         : init pulse starts a full clear to INIT_VALUE; busy
//                         stays high for the 2**ADDR_WIDTH clear cycles
//   req_*               : per-requester packed request buses; req_ready is
//                         the combinational one-hot grant
//   rsp_valid/rsp_data  : read response, one cycle after the read grant
//   ram_addr/di/we/do   : external RAM port (combinational read data in)
module lram_port_arbiter
  import lram_port_arbiter_pkg::*;
#(
  parameter int                    NUM_REQ    = DEF_NUM_REQ,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          init,
  output logic                          busy,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_di,
  output logic                          ram_we,
  input  logic [DATA_WIDTH-1:0]         ram_do
);

  localparam int                    PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state;
  logic [PTR_W-1:0]        ptr;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [NUM_REQ-1:0]      grant;
  logic [PTR_W-1:0]        gidx;
  logic                    serve_en;
  logic                    xfer;

  // Grants are suppressed while in INIT and while reset is held, so
  // req_ready drops the instant reset asserts.
  assign serve_en = (state == SERVE) && reset;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (serve_en),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);
  assign busy      = (state == INIT);

  // RAM drive: clear pattern in INIT, winner's request in SERVE, idle zeros.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (state == INIT) begin
      ram_we   = 1'b1;
      ram_addr = cnt;
      ram_di   = INIT_VALUE;
    end else if (xfer) begin
      ram_we   = req_we[gidx];
      ram_addr = req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_di   = req_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= SERVE;
      ptr       <= '0;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      // A read granted this cycle is answered next cycle; this also delivers
      // a read that coincides with the init pulse during the first INIT cycle.
      rsp_valid <= (xfer && !req_we[gidx]) ? grant : '0;
      if (xfer && !req_we[gidx]) begin
        rsp_data <= ram_do;
      end

      case (state)
        SERVE: begin
          if (xfer) begin
            ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
          end
          if (init) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        INIT: begin
          // init pulses are ignored here; the clear always runs to the end.
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state <= SERVE;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

  // Requesters must hold a pending request stable until it is granted.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_proto
    a_hold : assert property (@(posedge clock) disable iff (!reset)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] && $stable(req_we[i]) &&
         $stable(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
         $stable(req_wdata[i*DATA_WIDTH +: DATA_WIDTH])));
  end

endmodule

// File: tb/tb_lram_port_arbiter.sv
// Self-checking bench for lram_port_arbiter: a behavioural RAM, a reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_lram_port_arbiter;
  import lram_port_arbiter_pkg::*;

  localparam int         NR   = 4;
  localparam int         AW   = 6;
  localparam int         DW   = 8;
  localparam logic [7:0] INIT_VALUE = 8'h00;

  logic              clock = 1'b0;
  logic              reset;
  logic              init;
  logic              busy;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_di;
  logic              ram_we;
  logic [DW-1:0]     ram_do;

  lram_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INIT_VALUE)
  ) dut (
    .clock(clock), .reset(reset), .init(init), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_do(ram_do)
  );

  always #5 clock = ~clock;

  // External LUTRAM: synchronous write, combinational read.
  logic [DW-1:0] bram [LRAM_DEPTH];
  initial for (int i = 0; i < LRAM_DEPTH; i++) bram[i] = '0;
  always @(posedge clock) if (ram_we) bram[ram_addr] <= ram_di;
  assign ram_do = bram[ram_addr];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mm [LRAM_DEPTH];
  initial for (int i = 0; i < LRAM_DEPTH; i++) mm[i] = '0;
  bit            m_init = 0;
  int            m_cnt  = 0;
  int            m_ptr  = 0;
  logic [NR-1:0] m_rv   = '0;
  logic [DW-1:0] m_rd   = '0;

  int            mg, idx, cyc = 0;
  logic [NR-1:0] e_ready;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_di;

  int busy_cycles = 0;
  int ready_in_busy = 0;
  int g_idx[$], g_cyc[$], r_idx[$], r_cyc[$];

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      check("rst_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_ram_we", ram_we, 0);
      m_init = 0; m_cnt = 0; m_ptr = 0; m_rv = '0; m_rd = '0;
    end else begin
      mg = -1; e_ready = '0; e_we = 0; e_addr = '0; e_di = '0;
      if (m_init) begin
        e_we = 1; e_addr = AW'(m_cnt); e_di = INIT_VALUE;
      end else begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (mg < 0 && req_valid[idx]) mg = idx;
        end
        if (mg >= 0) begin
          e_ready[mg] = 1'b1;
          e_we   = req_we[mg];
          e_addr = req_addr[mg*AW +: AW];
          e_di   = req_wdata[mg*DW +: DW];
        end
      end
      check("req_ready", req_ready, e_ready);
      check("busy", busy, m_init);
      check("ram_we", ram_we, e_we);
      check("ram_addr", ram_addr, e_addr);
      check("ram_di", ram_di, e_di);
      check("rsp_valid", rsp_valid, m_rv);
      check("rsp_data", rsp_data, m_rd);

      if (busy) busy_cycles++;
      if (busy && req_ready != 0) ready_in_busy++;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin g_idx.push_back(i); g_cyc.push_back(cyc); end
        if (rsp_valid[i]) begin r_idx.push_back(i); r_cyc.push_back(cyc); end
      end

      // advance model to the next cycle
      m_rv = '0;
      if (m_init) begin
        mm[m_cnt] = INIT_VALUE;
        m_cnt++;
        if (m_cnt == LRAM_DEPTH) m_init = 0;
      end else begin
        if (mg >= 0) begin
          if (e_we) mm[e_addr] = e_di;
          else begin m_rv[mg] = 1'b1; m_rd = mm[e_addr]; end
          m_ptr = (mg + 1) % NR;
        end
        if (init) begin m_init = 1; m_cnt = 0; end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic set_req(input int i, input bit we, input int addr, input int data);
    req_we[i] = we;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*DW +: DW] = DW'(data);
  endtask

  // Hold the currently valid requests; requester i drops after quota[i] grants.
  task automatic serve(input int quota [NR]);
    int cnt [NR];
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    for (int b = 0; b < 200 && req_valid != 0; b++) begin
      @(negedge clock);
      for (int i = 0; i < NR; i++) if (req_ready[i]) cnt[i]++;
      tick();
      for (int i = 0; i < NR; i++) if (req_valid[i] && cnt[i] >= quota[i]) req_valid[i] = 1'b0;
    end
    check("serve_timeout", req_valid, 0);
  endtask

  task automatic do_req(input int i, input bit we, input int addr, input int data);
    int q [NR];
    for (int k = 0; k < NR; k++) q[k] = (k == i) ? 1 : 0;
    set_req(i, we, addr, data);
    req_valid[i] = 1'b1;
    serve(q);
  endtask

  task automatic wait_idle();
    int b;
    for (b = 0; b < 200; b++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check("busy_timeout", (b < 200) ? 1 : 0, 1);
  endtask

  int q2 [NR] = '{2, 1, 1, 1};
  int q3 [NR] = '{0, 1, 0, 1};
  int exp_g2 [5] = '{0, 1, 2, 3, 0};
  int exp_g3 [2] = '{3, 1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; init = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

    // Reset: a request pending during reset must not be granted.
    set_req(0, 1, 5, 8'hA5);
    req_valid[0] = 1'b1;
    tick(); tick();
    check("t0_ready_in_reset", req_ready, 4'b0000);
    check("t0_busy_in_reset", busy, 0);
    check("t0_rsp_data_in_reset", rsp_data, 8'h00);
    reset = 1'b1;

    // 1: write addr 5 = A5, then read it back one cycle after the grant.
    serve('{1, 0, 0, 0});
    do_req(0, 0, 5, 0);
    @(negedge clock);
    check("t1_rsp_valid", rsp_valid, 4'b0001);
    check("t1_rsp_data", rsp_data, 8'hA5);
    tick();

    // 2: four continuous readers -> grants 0,1,2,3,0, responses one cycle later.
    for (int i = 0; i < NR; i++) do_req(i, 1, 10 + i, 16 * i + 1);
    for (int i = 0; i < NR; i++) set_req(i, 0, 10 + i, 0);
    g_idx.delete(); g_cyc.delete(); r_idx.delete(); r_cyc.delete();
    req_valid = 4'b1111;
    serve(q2);
    @(negedge clock); #1;
    check("t2_grant_count", g_idx.size(), 5);
    check("t2_rsp_count", r_idx.size(), 5);
    for (int i = 0; i < 5 && i < g_idx.size() && i < r_idx.size(); i++) begin
      check("t2_grant_order", g_idx[i], exp_g2[i]);
      check("t2_rsp_order", r_idx[i], exp_g2[i]);
      check("t2_rsp_latency", r_cyc[i] - g_cyc[i], 1);
      if (i > 0) check("t2_back_to_back", g_cyc[i] - g_cyc[i-1], 1);
    end
    tick();

    // 3: pointer at 2 (after a req1 grant); req1 and req3 valid -> 3 then 1.
    do_req(1, 1, 20, 8'h77);
    set_req(1, 0, 20, 0);
    set_req(3, 0, 10, 0);
    g_idx.delete(); g_cyc.delete();
    req_valid = 4'b1010;
    serve(q3);
    check("t3_grant_count", g_idx.size(), 2);
    for (int i = 0; i < 2 && i < g_idx.size(); i++) check("t3_grant_order", g_idx[i], exp_g3[i]);

    // 4: write 3C to addr 63, init clears it; a read waits out the 64 cycles.
    do_req(0, 1, 63, 8'h3C);
    busy_cycles = 0; ready_in_busy = 0;
    init = 1'b1;
    tick();
    init = 1'b0;
    set_req(1, 0, 63, 0);
    req_valid[1] = 1'b1;
    wait_idle();
    check("t4_ready_after_init", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clock);
    check("t4_rsp_valid", rsp_valid, 4'b0010);
    check("t4_rsp_data", rsp_data, INIT_VALUE);
    check("t4_busy_cycles", busy_cycles, 64);
    check("t4_ready_in_busy", ready_in_busy, 0);
    tick();

    // 5: init together with a read; second init mid-INIT is ignored.
    do_req(2, 1, 7, 8'h11);
    busy_cycles = 0;
    set_req(2, 0, 7, 0);
    req_valid[2] = 1'b1;
    init = 1'b1;
    @(negedge clock);
    check("t5_ready_with_init", req_ready, 4'b0100);
    tick();
    init = 1'b0;
    req_valid[2] = 1'b0;
    @(negedge clock);
    check("t5_rsp_valid", rsp_valid, 4'b0100);
    check("t5_rsp_data", rsp_data, 8'h11);
    check("t5_busy", busy, 1);
    repeat (10) tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    wait_idle();
    check("t5_busy_cycles", busy_cycles, 64);
    tick();

    // 6: reset at INIT cycle 20; pending req0 wins the first cycle after.
    do_req(0, 1, 5, 8'h5A);
    init = 1'b1;
    tick();
    init = 1'b0;
    set_req(0, 0, 5, 0);
    req_valid[0] = 1'b1;
    repeat (20) tick();
    check("t6_busy_before_reset", busy, 1);
    reset = 1'b0;
    #1;
    check("t6_busy_reset", busy, 0);
    check("t6_rsp_valid_reset", rsp_valid, 4'b0000);
    check("t6_ready_reset", req_ready, 4'b0000);
    tick(); tick();
    reset = 1'b1;
    @(negedge clock);
    check("t6_first_grant", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clock);
    check("t6_rsp_valid", rsp_valid, 4'b0001);
    check("t6_rsp_data_cleared", rsp_data, INIT_VALUE);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
